stage_3_carry_resolver: RTL

- Sits directly downstream of the one-round normalization stage.
- Consumes each 9-bit byte candidate (8 data bits plus carry bit 8) that the normalization stage releases whenever s crosses the byte threshold.
- Resolves carry propagation with one buffered byte plus a counter of outstanding 0xFF bytes, as the AV1 precarry scheme requires.
- Emits final bitstream bytes over a valid/ready handshake; on flush, drains everything and marks the last byte.

---
 rtl/stage_3_carry_resolver.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/stage_3_carry_resolver.sv
// Purpose : resolves carry propagation for the range-coder byte stream (AV1 precarry scheme).
// Latency : a resolving candidate accepted in cycle N shows its first output byte in cycle N+1.
// Backpressure: out_ready=0 freezes the output byte and state; in_ready is high only while idle.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   in_valid/in_ready     candidate handshake; in_byte[BYTE_WIDTH] is the carry bit
//   in_flush              end of frame, drains all held state (wins over in_valid)
//   out_valid/out_ready   resolved byte handshake; out_last marks the final byte of a flush
//   err_overflow          sticky, set when an 0xFF run longer than the counter can hold was dropped
//
// A byte cannot be released until we know whether a later carry will bump it.
// The most recent non-0xFF byte is held in held_byte. Any 0xFF bytes after it
// are only counted in run, because a carry turns every one of them into 0x00
// and bumps held_byte by one. When the next non-0xFF candidate arrives, its
// carry bit settles the held byte and the whole run at once.

module stage_3_carry_resolver #(
    parameter int PEND_WIDTH = 16,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BYTE_WIDTH:0]   in_byte,
    input  logic                  in_flush,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BYTE_WIDTH-1:0] out_byte,
    output logic                  out_last,
    output logic                  err_overflow
);

    // State encoding.
    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] EMIT_BUF   = 3'd1;
    localparam logic [2:0] EMIT_RUN   = 3'd2;
    localparam logic [2:0] FLUSH_BUF  = 3'd3;
    localparam logic [2:0] FLUSH_RUN  = 3'd4;
    localparam logic [2:0] DONE_EMPTY = 3'd5;
    localparam logic [2:0] CLEAR      = 3'd6;

    localparam logic [PEND_WIDTH-1:0] RUN_MAX  = {PEND_WIDTH{1'b1}};
    localparam logic [PEND_WIDTH-1:0] RUN_ZERO = '0;
    localparam logic [PEND_WIDTH-1:0] RUN_ONE  = PEND_WIDTH'(1);
    localparam logic [BYTE_WIDTH-1:0] ALL_ONES = {BYTE_WIDTH{1'b1}};
    localparam logic [BYTE_WIDTH-1:0] ALL_ZERO = '0;

    logic [2:0]            state;
    logic [BYTE_WIDTH-1:0] held_byte;   // oldest unresolved byte
    logic                  held_vld;
    logic [BYTE_WIDTH-1:0] nxt_byte;    // resolving candidate, becomes held_byte once the run is out
    logic [PEND_WIDTH-1:0] run;         // number of 0xFF bytes queued behind held_byte
    logic                  cy;          // carry to apply to held_byte and the run

    logic                  cand_is_ff;
    logic                  run_nz;
    logic                  run_is_one;
    logic                  xfer;

    // A carry-free all-ones candidate only extends the pending run.
    assign cand_is_ff = (in_byte == {1'b0, ALL_ONES});
    assign run_nz     = (run != RUN_ZERO);
    assign run_is_one = (run == RUN_ONE);
    assign xfer       = out_valid & out_ready;

    // The outputs are decoded from registered state only, so they stay stable
    // while the sink stalls.
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = 1'b0;
        out_byte  = ALL_ZERO;
        out_last  = 1'b0;
        case (state)
            EMIT_BUF: begin
                out_valid = 1'b1;
                // Wraps mod 2^BYTE_WIDTH; a legal stream never carries out of the held byte.
                out_byte  = held_byte + {{(BYTE_WIDTH-1){1'b0}}, cy};
            end
            EMIT_RUN: begin
                out_valid = 1'b1;
                out_byte  = cy ? ALL_ZERO : ALL_ONES;
            end
            FLUSH_BUF: begin
                out_valid = 1'b1;
                out_byte  = held_byte;
                out_last  = ~run_nz;
            end
            FLUSH_RUN: begin
                out_valid = 1'b1;
                out_byte  = ALL_ONES;
                out_last  = run_is_one;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            held_byte    <= ALL_ZERO;
            held_vld     <= 1'b0;
            nxt_byte     <= ALL_ZERO;
            run          <= RUN_ZERO;
            cy           <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // in_ready is high here, so in_valid/in_flush are accepts.
                    if (in_flush) begin
                        if (held_vld) begin
                            state <= FLUSH_BUF;
                        end else if (run_nz) begin
                            state <= FLUSH_RUN;
                        end else begin
                            state <= DONE_EMPTY;
                        end
                    end else if (in_valid) begin
                        if (cand_is_ff) begin
                            // A run longer than the counter cannot be represented; the
                            // candidate is dropped and the error latched.
                            if (run != RUN_MAX) begin
                                run <= run + RUN_ONE;
                            end else begin
                                err_overflow <= 1'b1;
                            end
                        end else begin
                            cy       <= in_byte[BYTE_WIDTH];
                            nxt_byte <= in_byte[BYTE_WIDTH-1:0];
                            if (held_vld) begin
                                state <= EMIT_BUF;
                            end else if (run_nz) begin
                                state <= EMIT_RUN;
                            end else begin
                                // Nothing is pending for the carry to reach, so it is dropped.
                                held_byte <= in_byte[BYTE_WIDTH-1:0];
                                held_vld  <= 1'b1;
                                cy        <= 1'b0;
                            end
                        end
                    end
                end

                EMIT_BUF: begin
                    if (xfer) begin
                        if (run_nz) begin
                            state <= EMIT_RUN;
                        end else begin
                            held_byte <= nxt_byte;
                            held_vld  <= 1'b1;
                            cy        <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end

                EMIT_RUN: begin
                    if (xfer) begin
                        run <= run - RUN_ONE;
                        if (run_is_one) begin
                            held_byte <= nxt_byte;
                            held_vld  <= 1'b1;
                            cy        <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end

                FLUSH_BUF: begin
                    if (xfer) begin
                        state <= run_nz ? FLUSH_RUN : CLEAR;
                    end
                end

                FLUSH_RUN: begin
                    if (xfer) begin
                        run <= run - RUN_ONE;
                        if (run_is_one) begin
                            state <= CLEAR;
                        end
                    end
                end

                DONE_EMPTY: begin
                    state <= CLEAR;
                end

                CLEAR: begin
                    // err_overflow survives a flush; only reset clears it.
                    held_vld <= 1'b0;
                    run      <= RUN_ZERO;
                    cy       <= 1'b0;
                    state    <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
